// File: rtl/rgb_fade_sequencer.sv
// ---------------------------------------------------------------------------
// rgb_fade_sequencer
//
// Purpose:
//   Cycles an RGB LED through a 4-entry colour palette. The current duties
//   fade one step at a time toward the target colour. Once all three channels
//   match, the colour is held for a fixed number of step ticks. The sequencer
//   then advances to the next palette entry. Each channel is driven by a
//   6-bit PWM that compares its duty against a shared free-running counter.
//
// Parameters:
//   DIV   clk cycles per fade step tick (2..65535)
//   HOLD  step ticks a colour is held after arrival (1..65535)
//
// Ports:
//   clk      sole clock, rising edge
//   reset    synchronous, active-high reset
//   enable   1 = run the sequence, 0 = freeze it (duties retained)
//   wr_en    palette write strobe, one entry per cycle, accepted in any state
//   wr_addr  palette entry index 0..3
//   wr_data  colour {R[17:12], G[11:6], B[5:0]}
//   LEDG     registered PWM drive: bit0 = R, bit1 = G, bit2 = B
//   seq_idx  palette index of the current target colour
//   arrived  one-cycle pulse when all three duties reach the target
// ---------------------------------------------------------------------------
module rgb_fade_sequencer #(
   parameter int DIV  = 256,
   parameter int HOLD = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        wr_en,
   input  logic [1:0]  wr_addr,
   input  logic [17:0] wr_data,
   output logic [2:0]  LEDG,
   output logic [1:0]  seq_idx,
   output logic        arrived
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_FADE = 2'd2;
   localparam logic [1:0] S_HOLD = 2'd3;

   localparam logic [15:0] DIV_LAST  = 16'(DIV - 1);
   localparam logic [15:0] HOLD_LAST = 16'(HOLD - 1);

   logic [1:0]  state;
   logic [17:0] palette [4];
   logic [17:0] target;
   logic [5:0]  duty_r;
   logic [5:0]  duty_g;
   logic [5:0]  duty_b;
   logic [5:0]  pwm_cnt;
   logic [15:0] div_cnt;
   logic [15:0] hold_cnt;

   logic [5:0]  tgt_r;
   logic [5:0]  tgt_g;
   logic [5:0]  tgt_b;
   logic        at_target;
   logic        step_tick;

   assign tgt_r = target[17:12];
   assign tgt_g = target[11:6];
   assign tgt_b = target[5:0];

   assign at_target = (duty_r == tgt_r) && (duty_g == tgt_g) && (duty_b == tgt_b);
   assign step_tick = (div_cnt == DIV_LAST);

   // Moves a duty one step toward its goal. The duty is always bounded by a
   // 6-bit goal, so it can never wrap past 0 or 63.
   function automatic logic [5:0] approach(input logic [5:0] cur, input logic [5:0] goal);
      logic [5:0] nxt;
      nxt = cur;
      if (cur < goal) begin
         nxt = cur + 6'd1;
      end else if (cur > goal) begin
         nxt = cur - 6'd1;
      end
      return nxt;
   endfunction

   // ------------------------------------------------------------------------
   // PWM: the counter runs in every state. LEDG is registered, so it follows
   // duty/pwm_cnt with one cycle of latency.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values of the others, independent of block order.
      if (reset) begin
         pwm_cnt <= 6'd0;
         LEDG    <= 3'b000;
      end else begin
         pwm_cnt <= pwm_cnt + 6'd1;
         LEDG    <= {duty_b > pwm_cnt, duty_g > pwm_cnt, duty_r > pwm_cnt};
      end
   end

   // ------------------------------------------------------------------------
   // Palette: writes land at the edge where wr_en is high, in any state.
   // LOAD reads the pre-edge contents, so a same-cycle write to the entry
   // being loaded only shows up on the next visit.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: this small register-based palette is cleared on reset because
         // a freshly reset sequencer must fade toward black, not toward garbage.
         for (int i = 0; i < 4; i++) begin
            palette[i] <= 18'd0;
         end
      end else if (wr_en) begin
         palette[wr_addr] <= wr_data;
      end
   end

   // ------------------------------------------------------------------------
   // Sequencer FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         target   <= 18'd0;
         duty_r   <= 6'd0;
         duty_g   <= 6'd0;
         duty_b   <= 6'd0;
         div_cnt  <= 16'd0;
         hold_cnt <= 16'd0;
         seq_idx  <= 2'd0;
         arrived  <= 1'b0;
      end else begin
         arrived <= 1'b0;

         case (state)
            S_IDLE: begin
               div_cnt  <= 16'd0;
               hold_cnt <= 16'd0;
               if (enable) begin
                  state <= S_LOAD;
               end
            end

            S_LOAD: begin
               div_cnt  <= 16'd0;
               hold_cnt <= 16'd0;
               if (!enable) begin
                  state <= S_IDLE;
               end else begin
                  target <= palette[seq_idx];
                  state  <= S_FADE;
               end
            end

            S_FADE: begin
               if (!enable) begin
                  // Freeze: duties, target and seq_idx are kept as they are.
                  state    <= S_IDLE;
                  div_cnt  <= 16'd0;
                  hold_cnt <= 16'd0;
               end else if (at_target) begin
                  // Checked every cycle. A target equal to the current duties
                  // therefore passes straight through. The divider restarts so
                  // that HOLD always lasts exactly HOLD*DIV cycles.
                  arrived  <= 1'b1;
                  state    <= S_HOLD;
                  div_cnt  <= 16'd0;
                  hold_cnt <= 16'd0;
               end else if (step_tick) begin
                  div_cnt <= 16'd0;
                  duty_r  <= approach(duty_r, tgt_r);
                  duty_g  <= approach(duty_g, tgt_g);
                  duty_b  <= approach(duty_b, tgt_b);
               end else begin
                  div_cnt <= div_cnt + 16'd1;
               end
            end

            S_HOLD: begin
               if (!enable) begin
                  state    <= S_IDLE;
                  div_cnt  <= 16'd0;
                  hold_cnt <= 16'd0;
               end else if (step_tick) begin
                  div_cnt <= 16'd0;
                  if (hold_cnt == HOLD_LAST) begin
                     hold_cnt <= 16'd0;
                     seq_idx  <= seq_idx + 2'd1;
                     state    <= S_LOAD;
                  end else begin
                     hold_cnt <= hold_cnt + 16'd1;
                  end
               end else begin
                  div_cnt <= div_cnt + 16'd1;
               end
            end

            // NOTE: the default arm is kept even though all four encodings are
            // covered, so the case stays complete if the state width ever grows.
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
